store_merge_ram: RTL and testbench

Store-side counterpart to the load-path byte extractor in the DataPath. It accepts SB/SH/SW store requests from the MEM stage and writes them into the word-wide data RAM, which has no byte enables. Word stores are written directly. Byte and halfword stores run a read-modify-write sequence: read the containing word, replace the addressed lane(s), write the word back.

---
 rtl/store_merge_ram_pkg.sv | 30 +++
 rtl/store_merge_ram_lane_merge.sv | 37 +++
 rtl/store_merge_ram.sv | 95 +++++++++
 tb/tb_store_merge_ram.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_ram_pkg.sv
// Shared definitions for the store path: size encodings (same as the load
// path), FSM state type and the request legality check.
package store_merge_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        MERGE = 2'b10,
        WRITE = 2'b11
    } state_t;

    // High for an illegal size or a half/word store not naturally aligned.
    function automatic logic req_illegal(input logic [1:0] size,
                                         input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_ram_lane_merge.sv
// Write-direction inverse of the load lane extractor: drops right-aligned
// store data into the addressed byte/half lane(s) of an existing word.
module store_lane_merge
    import store_merge_ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged
);

    // Replace the selected lane(s); every other bit comes from the old word.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged[31:16] = store_data[15:0];
                end else begin
                    merged[15:0]  = store_data[15:0];
                end
            end
            SZ_WORD: merged = store_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_ram.sv
// Store unit in front of a word-wide data RAM without byte enables.
// Word stores write directly; byte/half stores do read-modify-write.
module store_merge_ram
    import store_merge_ram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [1:0]        i_size,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    state_t            state;
    logic [1:0]        size_q;
    logic [1:0]        offset_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              err_q;
    logic [31:0]       merged_word;

    // Address bits above the RAM range wrap and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[31:ADDR_W+2];

    store_lane_merge u_lane_merge (
        .size       (size_q),
        .offset     (offset_q),
        .old_word   (i_ram_rdata),
        .store_data (wdata_q),
        .merged     (merged_word)
    );

    // FSM, request latches and RAM-side registers.
    // ram_addr_q only moves on a legal request so an errored one leaves the
    // previously presented RAM address untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            size_q      <= '0;
            offset_q    <= '0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        size_q   <= i_size;
                        offset_q <= i_addr[1:0];
                        wdata_q  <= i_wdata;
                        if (req_illegal(i_size, i_addr[1:0])) begin
                            err_q <= 1'b1;
                        end else begin
                            ram_addr_q <= i_addr[ADDR_W+1:2];
                            if (i_size == SZ_WORD) begin
                                ram_wdata_q <= i_wdata;
                                state       <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ:  state <= MERGE;
                MERGE: begin
                    ram_wdata_q <= merged_word;
                    state       <= WRITE;
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (state == IDLE);
    assign o_ram_we    = (state == WRITE);
    assign o_done      = (state == WRITE);
    assign o_err       = err_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_store_merge_ram.sv
// Self-checking bench for store_merge_ram with a synchronous-read RAM model
// and a scoreboard of expected RAM writes.
module tb_store_merge_ram;

    localparam int ADDR_W = 10;
    localparam logic [1:0] B_SZ = 2'b00;
    localparam logic [1:0] H_SZ = 2'b01;
    localparam logic [1:0] W_SZ = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic [1:0]        size = '0;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0] mem       [0:(1<<ADDR_W)-1];
    logic [31:0] model_mem [0:(1<<ADDR_W)-1];
    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [31:0]       poke_data = '0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;
    wr_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    store_merge_ram #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_size      (size),
        .o_done      (done),
        .o_err       (err),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous read, whole-word write, bench preload port.
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        model_mem[a] = d;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Drive a request (called at a negedge), push the expected write when
    // legal and tracked, and return right after the accepting edge.
    task automatic drive_req(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input bit track);
        logic [ADDR_W-1:0] wa;
        logic [31:0] old, nw;
        int sh;
        int n;
        bit legal;
        wr_t e;
        wa = a[ADDR_W+1:2];
        legal = !((sz == 2'b11) || (sz == H_SZ && a[0]) || (sz == W_SZ && a[1:0] != 2'b00));
        if (legal && track) begin
            old = model_mem[wa];
            if (sz == B_SZ) begin
                sh = int'(a[1:0]) * 8;
                nw = (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            end else if (sz == H_SZ) begin
                sh = a[1] ? 16 : 0;
                nw = (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
            end else begin
                nw = d;
            end
            model_mem[wa] = nw;
            e.a = wa;
            e.d = nw;
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        size  = sz;
        addr  = a;
        wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || ram_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b done=%b err=%b we=%b, required 1 0 0 0",
                     req_ready, done, err, ram_we);
        end
        tests++;
        if (ram_addr !== '0 || ram_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_ram: addr=%h wdata=%h, required 0 0", ram_addr, ram_wdata);
        end
    endtask

    task automatic test_sb();
        int lat;
        wr_t e;
        poke(10'd1, 32'hAABB_CCDD);
        drive_req(B_SZ, 32'h0000_0006, 32'h1122_3344, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (ram_we !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL sb_read_cycle: we=%b ready=%b, required 0 0", ram_we, req_ready);
        end
        wait_done(lat);
        tests++;
        if (done !== 1'b1 || lat != 3) begin
            fails++;
            $display("FAIL sb_latency: done=%b at cycle %0d, required done=1 at 3", done, lat);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_write: scoreboard empty, required one entry");
        end else begin
            e = exp_q.pop_front();
            if (ram_we !== 1'b1 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL sb_write: we=%b addr=%h data=%h, required 1 %h %h",
                         ram_we, ram_addr, ram_wdata, e.a, e.d);
            end
        end
    endtask

    task automatic test_sh();
        int lat;
        wr_t e;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_000A;
        addrs[1] = 32'h0000_0008;
        for (int i = 0; i < 2; i++) begin
            poke(10'd2, 32'hAABB_CCDD);
            drive_req(H_SZ, addrs[i], 32'h1122_3344, 1'b1);
            @(negedge clk);
            req_valid = 1'b0;
            wait_done(lat);
            tests++;
            if (done !== 1'b1 || lat != 3) begin
                fails++;
                $display("FAIL sh_latency[%0d]: done=%b at cycle %0d, required 1 at 3", i, done, lat);
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sh_write[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (ram_we !== 1'b1 || ram_addr !== e.a || ram_wdata !== e.d) begin
                    fails++;
                    $display("FAIL sh_write[%0d]: we=%b addr=%h data=%h, required 1 %h %h",
                             i, ram_we, ram_addr, ram_wdata, e.a, e.d);
                end
            end
        end
    endtask

    task automatic test_sw();
        wr_t e;
        drive_req(W_SZ, 32'h0000_000C, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sw_write: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (done !== 1'b1 || ram_we !== 1'b1 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL sw_write: done=%b we=%b addr=%h data=%h, required 1 1 %h %h",
                         done, ram_we, ram_addr, ram_wdata, e.a, e.d);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0]  szs [3];
        logic [31:0] ads [3];
        szs[0] = H_SZ;  ads[0] = 32'h0000_0101;
        szs[1] = W_SZ;  ads[1] = 32'h0000_0102;
        szs[2] = 2'b11; ads[2] = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            drive_req(szs[i], ads[i], 32'h5555_AAAA, 1'b1);
            @(negedge clk);
            req_valid = 1'b0;
            tests++;
            if (err !== 1'b1 || ram_we !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL err_pulse[%0d]: err=%b we=%b ready=%b done=%b, required 1 0 1 0",
                         i, err, ram_we, req_ready, done);
            end
            @(negedge clk);
            tests++;
            if (err !== 1'b0 || ram_we !== 1'b0) begin
                fails++;
                $display("FAIL err_single[%0d]: err=%b we=%b, required 0 0", i, err, ram_we);
            end
        end
        tests++;
        if (ram_addr !== 10'd3) begin
            fails++;
            $display("FAIL err_addr_hold: addr=%h, required 003", ram_addr);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bad;
        wr_t e;
        poke(10'd5, 32'h1234_5678);
        drive_req(B_SZ, 32'h0000_0014, 32'h0000_0099, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || ram_we !== 1'b0 ||
            ram_addr !== '0 || ram_wdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_state: ready=%b done=%b err=%b we=%b addr=%h wdata=%h, required 1 0 0 0 0 0",
                     req_ready, done, err, ram_we, ram_addr, ram_wdata);
        end
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ram_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (bad || mem[5] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL rst_mid_quiet: stray activity=%b mem=%h, required 0 12345678", bad, mem[5]);
        end
        drive_req(B_SZ, 32'h0000_0014, 32'h0000_0099, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(lat);
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rst_mid_retry: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (done !== 1'b1 || lat != 3 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL rst_mid_retry: done=%b lat=%0d addr=%h data=%h, required 1 3 %h %h",
                         done, lat, ram_addr, ram_wdata, e.a, e.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int c1, c2;
        wr_t e;
        poke(10'd0, 32'h0102_0304);
        drive_req(B_SZ, 32'h0000_0000, 32'h0000_00AA, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(lat);
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_sb0: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (done !== 1'b1 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL b2b_sb0: done=%b addr=%h data=%h, required 1 %h %h",
                         done, ram_addr, ram_wdata, e.a, e.d);
            end
        end
        drive_req(B_SZ, 32'h0000_0003, 32'h0000_00BB, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(lat);
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_sb3: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (done !== 1'b1 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL b2b_sb3: done=%b addr=%h data=%h, required 1 %h %h",
                         done, ram_addr, ram_wdata, e.a, e.d);
            end
        end
        @(negedge clk);
        tests++;
        if (mem[0] !== 32'hBB02_03AA) begin
            fails++;
            $display("FAIL b2b_ram_word: mem0=%h, required bb0203aa", mem[0]);
        end
        drive_req(W_SZ, 32'h0000_0100, 32'hCAFE_0001, 1'b1);
        @(negedge clk);
        c1 = cyc;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_sw0: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (done !== 1'b1 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL b2b_sw0: done=%b addr=%h data=%h, required 1 %h %h",
                         done, ram_addr, ram_wdata, e.a, e.d);
            end
        end
        drive_req(W_SZ, 32'h0000_0104, 32'hCAFE_0002, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        c2 = cyc;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL b2b_sw1: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (done !== 1'b1 || (c2 - c1) != 2 || ram_addr !== e.a || ram_wdata !== e.d) begin
                fails++;
                $display("FAIL b2b_sw1: done=%b spacing=%0d addr=%h data=%h, required 1 2 %h %h",
                         done, c2 - c1, ram_addr, ram_wdata, e.a, e.d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
